// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter sharing one spi_master among N_REQ clients, with a
// minimum idle gap between transfers and a watchdog on a stalled master.
module spi_req_arbiter #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned GAP_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [N_REQ-1:0]            req_i,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [N_REQ-1:0]            grant_o,
  output logic [N_REQ-1:0]            done_o,
  output logic [N_REQ-1:0]            err_o,
  output logic [DATA_WIDTH-1:0]       rdata_o,
  output logic                        busy_o,
  output logic                        m_start_o,
  output logic [DATA_WIDTH-1:0]       m_data_in_o,
  input  logic                        m_finish_i,
  input  logic [DATA_WIDTH-1:0]       m_data_out_i
);

  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned GapW = $clog2(GAP_CYCLES + 2);
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {StIdle, StStart, StWait, StGap} state_e;

  state_e                  state_q, state_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [IdxW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [GapW-1:0]         gap_cnt_q, gap_cnt_d;
  logic [TmoW-1:0]         tmo_cnt_q, tmo_cnt_d;
  logic [N_REQ-1:0]        grant_q, grant_d;
  logic [N_REQ-1:0]        done_q, done_d;
  logic [N_REQ-1:0]        err_q, err_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    busy_q, busy_d;
  logic                    m_start_q, m_start_d;
  logic [DATA_WIDTH-1:0]   m_data_in_q, m_data_in_d;

  logic                    win_found;
  logic [IdxW-1:0]         win_idx;
  logic [31:0]             scan_idx;
  logic                    timed_out;

  // First pending request at or above rr_ptr, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      scan_idx = 32'(rr_ptr_q) + k;
      if (scan_idx >= N_REQ) begin
        scan_idx = scan_idx - N_REQ;
      end
      if (!win_found && req_i[scan_idx[IdxW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan_idx[IdxW-1:0];
      end
    end
  end

  assign timed_out = (tmo_cnt_q >= TmoW'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rr_ptr_d    = rr_ptr_q;
    gap_cnt_d   = gap_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    grant_d     = grant_q;
    done_d      = '0;
    err_d       = '0;
    rdata_d     = rdata_q;
    m_start_d   = 1'b0;
    m_data_in_d = m_data_in_q;

    unique case (state_q)
      StIdle: begin
        tmo_cnt_d = '0;
        if (win_found) begin
          idx_d       = win_idx;
          m_data_in_d = req_data_i[32'(win_idx) * DATA_WIDTH +: DATA_WIDTH];
          grant_d     = N_REQ'(1) << win_idx;
          m_start_d   = 1'b1;
          state_d     = StStart;
        end
      end
      StStart: begin
        // The watchdog counts from the start cycle itself.
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        state_d   = StWait;
      end
      StWait: begin
        if (m_finish_i || timed_out) begin
          done_d    = grant_q;
          err_d     = m_finish_i ? '0 : grant_q;
          rdata_d   = m_finish_i ? m_data_out_i : '0;
          grant_d   = '0;
          gap_cnt_d = '0;
          rr_ptr_d  = (32'(idx_q) == N_REQ - 1) ? '0 : idx_q + 1'b1;
          state_d   = StGap;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      StGap: begin
        if (gap_cnt_q == GapW'(GAP_CYCLES)) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      rr_ptr_q    <= '0;
      gap_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      grant_q     <= '0;
      done_q      <= '0;
      err_q       <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      m_start_q   <= 1'b0;
      m_data_in_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rr_ptr_q    <= rr_ptr_d;
      gap_cnt_q   <= gap_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
      m_start_q   <= m_start_d;
      m_data_in_q <= m_data_in_d;
    end
  end

  assign grant_o     = grant_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign rdata_o     = rdata_q;
  assign busy_o      = busy_q;
  assign m_start_o   = m_start_q;
  assign m_data_in_o = m_data_in_q;

endmodule
